freq_synth_gen: RTL and testbench

//  Programmable square-wave generator that produces the test signal for the frequency meter.

---
 rtl/freq_pkg.sv | 20 ++
 rtl/seq_divider.sv | 68 ++++++
 rtl/freq_synth_gen.sv | 181 ++++++++++++++++++
 tb/tb_freq_synth_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants, FSM state type and BCD helper for the frequency synthesiser.
package freq_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned CNT_W  = 27;
    localparam int unsigned FREQ_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DIV,
        COMMIT
    } state_e;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; DVD_W steps after a start pulse.
module seq_divider #(
    parameter int unsigned DVD_W = 27,
    parameter int unsigned DVS_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int unsigned STEP_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0]  quo_q, quo_d;
    logic [DVS_W-1:0]  rem_q, rem_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              run_q, run_d;
    logic [DVS_W:0]    rem_sh;
    logic [DVS_W:0]    diff;
    logic              fits;

    // done marks the final step: the quotient is complete from the next cycle on.
    // divisor is read live every step, so it must stay stable while running.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        step_d = step_q;
        run_d  = run_q;
        rem_sh = {rem_q, quo_q[DVD_W-1]};
        fits   = rem_sh >= {1'b0, divisor};
        diff   = rem_sh - {1'b0, divisor};
        done   = run_q && (step_q == STEP_W'(DVD_W - 1));

        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            step_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            quo_d  = {quo_q[DVD_W-2:0], fits};
            rem_d  = fits ? diff[DVS_W-1:0] : rem_sh[DVS_W-1:0];
            step_d = step_q + STEP_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            step_q <= step_d;
            run_q  <= run_d;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/freq_synth_gen.sv
// Programmable square-wave generator: BCD Hz in, half-period by sequential division,
// new settings applied only on a sigout toggle boundary.
module freq_synth_gen #(
    parameter int unsigned CLK_HZ = freq_pkg::CLK_HZ,
    parameter int unsigned DIGITS = freq_pkg::DIGITS,
    parameter int unsigned CNT_W  = freq_pkg::CNT_W
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                load,
    output logic                busy,
    output logic                err,
    output logic [13:0]         freq_bin,
    output logic                sigout
);

    import freq_pkg::*;

    localparam int unsigned      IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] HALF_DIVIDEND = CNT_W'(CLK_HZ / 2);

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [FREQ_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]    dig_q, dig_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    pend_half_q, pend_half_d;
    logic [FREQ_W-1:0]   pend_freq_q, pend_freq_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sig_q, sig_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;

    logic [3:0]          digit;
    logic                all_valid;
    logic                div_start;
    logic                div_done;
    logic [CNT_W-1:0]    quotient;

    always_comb begin
        digit     = '0;
        all_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == dig_q) begin
                digit = bcd_q[i*4 +: 4];
            end
            if (!bcd_valid(bcd_in[i*4 +: 4])) begin
                all_valid = 1'b0;
            end
        end
    end

    // The divider is armed on the last CONV edge; acc is final from the next cycle.
    assign div_start = (state_q == CONV) && (dig_q == '0);

    seq_divider #(
        .DVD_W(CNT_W),
        .DVS_W(FREQ_W)
    ) u_div (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(HALF_DIVIDEND),
        .divisor (acc_q),
        .done    (div_done),
        .quotient(quotient)
    );

    always_comb begin
        state_d      = state_q;
        bcd_d        = bcd_q;
        acc_d        = acc_q;
        dig_d        = dig_q;
        err_d        = err_q;
        pend_half_d  = pend_half_q;
        pend_freq_d  = pend_freq_q;
        pend_valid_d = pend_valid_q;
        half_d       = half_q;
        cnt_d        = cnt_q;
        sig_d        = sig_q;
        freq_d       = freq_q;

        // Generator first: a COMMIT in the same cycle must win over the consume below.
        if (half_q == '0) begin
            cnt_d = '0;
            sig_d = 1'b0;
            if (pend_valid_q) begin
                half_d       = pend_half_q;
                freq_d       = pend_freq_q;
                pend_valid_d = 1'b0;
            end
        end else if (cnt_q == half_q - CNT_W'(1)) begin
            cnt_d = '0;
            sig_d = ~sig_q;
            if (pend_valid_q) begin
                half_d       = pend_half_q;
                freq_d       = pend_freq_q;
                pend_valid_d = 1'b0;
                if (pend_half_q == '0) begin
                    sig_d = 1'b0;
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (!all_valid) begin
                        err_d = 1'b1;
                    end else begin
                        bcd_d   = bcd_in;
                        err_d   = 1'b0;
                        acc_d   = '0;
                        dig_d   = IDX_W'(DIGITS - 1);
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                acc_d = acc_q * FREQ_W'(10) + FREQ_W'(digit);
                if (dig_q == '0) begin
                    state_d = DIV;
                end else begin
                    dig_d = dig_q - IDX_W'(1);
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pend_half_d  = (acc_q == '0) ? '0 : quotient;
                pend_freq_d  = acc_q;
                pend_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bcd_q        <= '0;
            acc_q        <= '0;
            dig_q        <= '0;
            err_q        <= 1'b0;
            pend_half_q  <= '0;
            pend_freq_q  <= '0;
            pend_valid_q <= 1'b0;
            half_q       <= '0;
            cnt_q        <= '0;
            sig_q        <= 1'b0;
            freq_q       <= '0;
        end else begin
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            acc_q        <= acc_d;
            dig_q        <= dig_d;
            err_q        <= err_d;
            pend_half_q  <= pend_half_d;
            pend_freq_q  <= pend_freq_d;
            pend_valid_q <= pend_valid_d;
            half_q       <= half_d;
            cnt_q        <= cnt_d;
            sig_q        <= sig_d;
            freq_q       <= freq_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign freq_bin = freq_q;
    assign sigout   = sig_q;

endmodule

// File: tb/tb_freq_synth_gen.sv
// Scoreboard bench for freq_synth_gen at CLK_HZ=100_000, CNT_W=17.
module tb_freq_synth_gen;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load   = 1'b0;
    logic        busy;
    logic        err;
    logic [13:0] freq_bin;
    logic        sigout;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic lvl;
        int   len;   // 0 = segment of unknown length, not checked
    } seg_t;

    seg_t seg_q[$];
    int   busy_q[$];

    freq_synth_gen #(
        .CLK_HZ(100_000),
        .DIGITS(4),
        .CNT_W (17)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .bcd_in  (bcd_in),
        .load    (load),
        .busy    (busy),
        .err     (err),
        .freq_bin(freq_bin),
        .sigout  (sigout)
    );

    always #5 sysclk = ~sysclk;

    // Monitor: measures busy pulses and sigout level segments, compares against queues.
    int   busy_run = 0;
    int   seg_len  = 0;
    logic prev_sig = 1'b0;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            busy_run = 0;
            seg_len  = 0;
            prev_sig = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                compared++;
                if (busy_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL busy_len: unexpected busy pulse of %0d cycles, required none", busy_run);
                end else begin
                    int exp_len;
                    exp_len = busy_q.pop_front();
                    if (busy_run != exp_len) begin
                        mismatched++;
                        $display("FAIL busy_len: got %0d cycles, required %0d", busy_run, exp_len);
                    end
                end
                busy_run = 0;
            end

            if (sigout !== prev_sig) begin
                if (seg_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sig_seg: unexpected toggle after level %0b for %0d cycles, required none",
                             prev_sig, seg_len);
                end else begin
                    seg_t e;
                    e = seg_q.pop_front();
                    if (e.len != 0) begin
                        compared++;
                        if (e.lvl !== prev_sig || e.len != seg_len) begin
                            mismatched++;
                            $display("FAIL sig_seg: got level %0b for %0d cycles, required level %0b for %0d",
                                     prev_sig, seg_len, e.lvl, e.len);
                        end
                    end
                end
                prev_sig = sigout;
                seg_len  = 1;
            end else begin
                seg_len++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        @(posedge sysclk);
        #1;
        bcd_in = v;
        load   = 1'b1;
        @(posedge sysclk);
        #1;
        load   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((busy_q.size() != 0 || seg_q.size() != 0) && n < max_cyc) begin
            @(negedge sysclk);
            n++;
        end
        if (busy_q.size() != 0 || seg_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: timeout with %0d busy / %0d segment events outstanding, required 0",
                     name, busy_q.size(), seg_q.size());
            busy_q.delete();
            seg_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_freq", int'(freq_bin), 0);
        chk("rst_sig", int'(sigout), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge sysclk);

        // 1: 100 Hz -> half 500
        busy_q.push_back(22);
        seg_q.push_back('{1'b0, 0});
        seg_q.push_back('{1'b1, 500});
        seg_q.push_back('{1'b0, 500});
        do_load(16'h0100);
        chk("t1_busy_up", int'(busy), 1);
        wait_drain("t1_drain", 3000);
        chk("t1_freq", int'(freq_bin), 100);

        // 2: retune to 250 Hz mid-half; old half completes, then 200-cycle halves
        busy_q.push_back(22);
        seg_q.push_back('{1'b1, 500});
        seg_q.push_back('{1'b0, 200});
        seg_q.push_back('{1'b1, 200});
        seg_q.push_back('{1'b0, 200});
        repeat (100) @(posedge sysclk);
        do_load(16'h0250);
        chk("t2_freq_held", int'(freq_bin), 100);
        wait_drain("t2_drain", 3000);
        chk("t2_freq", int'(freq_bin), 250);

        // 3: invalid digit rejected, output untouched; valid load clears err
        seg_q.push_back('{1'b1, 200});
        seg_q.push_back('{1'b0, 200});
        do_load(16'h00A5);
        chk("t3_err_set", int'(err), 1);
        chk("t3_busy_low", int'(busy), 0);
        repeat (5) @(posedge sysclk);
        #1;
        chk("t3_err_hold", int'(err), 1);
        chk("t3_busy_still", int'(busy), 0);
        chk("t3_freq", int'(freq_bin), 250);
        busy_q.push_back(22);
        do_load(16'h0250);
        chk("t3_err_clr", int'(err), 0);
        wait_drain("t3_drain", 2000);
        chk("t3_freq_after", int'(freq_bin), 250);

        // 4: load 0 while running -> stops low at next boundary
        busy_q.push_back(22);
        seg_q.push_back('{1'b1, 200});
        do_load(16'h0000);
        wait_drain("t4_drain", 1000);
        repeat (300) @(posedge sysclk);
        #1;
        chk("t4_sig_off", int'(sigout), 0);
        chk("t4_freq", int'(freq_bin), 0);

        // 5: restart at 250 Hz, then spam loads during busy and reset mid-DIV
        busy_q.push_back(22);
        seg_q.push_back('{1'b0, 0});
        do_load(16'h0250);
        wait_drain("t5_start", 1000);
        @(posedge sysclk);
        #1;
        bcd_in = 16'h0100;
        load   = 1'b1;
        @(posedge sysclk);
        #1;
        bcd_in = 16'h00A5;
        for (int i = 0; i < 10; i++) begin
            @(posedge sysclk);
            #1;
            chk("t5_busy", int'(busy), 1);
            chk("t5_err", int'(err), 0);
        end
        chk("t5_sig_pre", int'(sigout), 1);
        @(posedge sysclk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sig", int'(sigout), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_err", int'(err), 0);
        chk("t5_rst_freq", int'(freq_bin), 0);
        load = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge sysclk);
        #1;
        chk("t5_post_busy", int'(busy), 0);
        chk("t5_post_sig", int'(sigout), 0);
        chk("t5_post_freq", int'(freq_bin), 0);

        // 6: 9999 Hz -> half = floor(50000/9999) = 5
        busy_q.push_back(22);
        seg_q.push_back('{1'b0, 0});
        seg_q.push_back('{1'b1, 5});
        seg_q.push_back('{1'b0, 5});
        seg_q.push_back('{1'b1, 5});
        seg_q.push_back('{1'b0, 5});
        do_load(16'h9999);
        wait_drain("t6_drain", 500);
        chk("t6_freq", int'(freq_bin), 9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
